// File: rtl/adc_spi_controller_if.sv
// ADC serial bus and receiver framing signals driven by adc_spi_controller.
// master = controller side, slave = ADC / receiver side.
interface adc_spi_controller_if;
    logic       oADC_CS_n;
    logic       oADC_DCLK;
    logic       oADC_DIN;
    logic [6:0] oCOUNT_80;
    logic       oTRANS_EN;
    logic       oDONE;

    modport master (
        output oADC_CS_n, oADC_DCLK, oADC_DIN, oCOUNT_80, oTRANS_EN, oDONE
    );
    modport slave (
        input  oADC_CS_n, oADC_DCLK, oADC_DIN, oCOUNT_80, oTRANS_EN, oDONE
    );
endinterface

// File: rtl/adc_spi_controller.sv
// Touch-ADC SPI frame sequencer: debounced pen-down starts an 80-step X/Y frame; oDONE pulses when it ends.
// Latency: DEB_CYCLES pen cycles (+2 sync) to CS_n low, frame 80*CLK_DIV cycles; no backpressure, frames always complete.
// Optional macro ADC_REPEAT_EN: re-run frames every PERIOD cycles while the pen stays down.
module adc_spi_controller #(
    parameter int         CLK_DIV    = 25,
    parameter int         DEB_CYCLES = 50000,
    parameter int         PERIOD     = 500000,
    parameter logic [7:0] CMD_X      = 8'hD0,
    parameter logic [7:0] CMD_Y      = 8'h90
) (
    input  logic                        iCLK,
    input  logic                        iRST_n,
    input  logic                        iEN,
    input  logic                        iPENIRQ_n,
    adc_spi_controller_if.master        bus
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    // The debounce count includes the IDLE cycle that first saw the pen, hence the minimum of 2.
    if (CLK_DIV < 2 || DEB_CYCLES < 2 || PERIOD < 1) begin : g_bad_params
        $error("adc_spi_controller: CLK_DIV and DEB_CYCLES must be >= 2, PERIOD >= 1");
    end

    typedef enum logic [2:0] {IDLE, DEBOUNCE, TRANS, DONE, HOLD} state_t;

    state_t             state;
    logic               pen_s1, pen_s2;
    logic               pen;
    logic               start;
    logic [DEB_W-1:0]   deb_cnt;
    logic [PRE_W-1:0]   presc;
    logic [6:0]         count;
    logic               cs_n, dclk, din, trans_en, done;
`ifdef ADC_REPEAT_EN
    logic [31:0]        period_cnt;
`endif

    function automatic logic din_for(input logic [6:0] c);
        if (c < 7'd16)
            return CMD_X[3'd7 - c[3:1]];
        else if (c >= 7'd32 && c < 7'd48)
            return CMD_Y[3'd7 - c[3:1]];
        else
            return 1'b0;
    endfunction

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_s1 <= 1'b1;
            pen_s2 <= 1'b1;
        end else begin
            pen_s1 <= iPENIRQ_n;
            pen_s2 <= pen_s1;
        end
    end

    assign pen = ~pen_s2;

    always_comb begin
        start = 1'b0;
        if (state == DEBOUNCE && iEN && pen && deb_cnt == DEB_W'(DEB_CYCLES - 2))
            start = 1'b1;
`ifdef ADC_REPEAT_EN
        // A short PERIOD saturates here, so the next frame starts as soon as HOLD is reached.
        if (state == HOLD && iEN && pen && period_cnt >= 32'(PERIOD - 1))
            start = 1'b1;
`endif
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            deb_cnt  <= '0;
            presc    <= '0;
            count    <= '0;
            cs_n     <= 1'b1;
            dclk     <= 1'b0;
            din      <= 1'b0;
            trans_en <= 1'b0;
            done     <= 1'b0;
`ifdef ADC_REPEAT_EN
            period_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ADC_REPEAT_EN
            if (period_cnt != '1)
                period_cnt <= period_cnt + 32'd1;
`endif
            if (start) begin
                state    <= TRANS;
                presc    <= '0;
                count    <= '0;
                cs_n     <= 1'b0;
                trans_en <= 1'b1;
                dclk     <= 1'b0;
                din      <= CMD_X[7];
`ifdef ADC_REPEAT_EN
                period_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        deb_cnt <= '0;
                        if (iEN && pen)
                            state <= DEBOUNCE;
                    end
                    DEBOUNCE: begin
                        if (!iEN || !pen)
                            state <= IDLE;
                        else
                            deb_cnt <= deb_cnt + 1'b1;
                    end
                    TRANS: begin
                        if (presc == PRE_W'(CLK_DIV - 1)) begin
                            presc <= '0;
                            if (count == 7'd79) begin
                                state    <= DONE;
                                count    <= '0;
                                cs_n     <= 1'b1;
                                trans_en <= 1'b0;
                                dclk     <= 1'b0;
                                din      <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                count <= count + 7'd1;
                                dclk  <= ~count[0];
                                din   <= din_for(count + 7'd1);
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    DONE:
                        state <= HOLD;
                    HOLD: begin
                        if (!iEN || !pen)
                            state <= IDLE;
                    end
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oADC_CS_n = cs_n;
    assign bus.oADC_DCLK = dclk;
    assign bus.oADC_DIN  = din;
    assign bus.oCOUNT_80 = count;
    assign bus.oTRANS_EN = trans_en;
    assign bus.oDONE     = done;
endmodule
